// File: rtl/blue_motion_pkg.sv
// Shared definitions for the blue sprite: vertical-state encoding, contact flag
// indices, sprite/screen geometry and the step-burst request handed to the sequencer.
package blue_motion_pkg;

  localparam int SPRITE_W = 23;
  localparam int SPRITE_H = 45;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [1:0] V_GROUND = 2'd0;
  localparam logic [1:0] V_RISE   = 2'd1;
  localparam logic [1:0] V_FALL   = 2'd2;

  localparam int COLL_FLOOR  = 0;
  localparam int COLL_CEIL   = 1;
  localparam int COLL_WALL_R = 2;
  localparam int COLL_WALL_L = 3;

  localparam logic [1:0] SEQ_IDLE   = 2'd0;
  localparam logic [1:0] SEQ_HSTEP  = 2'd1;
  localparam logic [1:0] SEQ_VSTEP  = 2'd2;
  localparam logic [1:0] SEQ_SETTLE = 2'd3;

  typedef struct packed {
    logic [3:0] hx;
    logic [3:0] hv;
  } step_req_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/blue_motion_step_seq.sv
// Pixel-step sequencer: runs hx horizontal then hv vertical single-pixel steps,
// each followed by a settle cycle so the contact flags catch up with the position.
module blue_step_seq
  import blue_motion_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start,
  input  step_req_t req,
  input  logic      h_abort,
  input  logic      v_abort,
  output logic      h_step,
  output logic      v_step,
  output logic      busy
);

  logic [1:0] state;
  logic [3:0] hx_cnt;
  logic [3:0] hv_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= SEQ_IDLE;
      hx_cnt <= 4'd0;
      hv_cnt <= 4'd0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            hx_cnt <= req.hx;
            hv_cnt <= req.hv;
            // An empty burst still spends one busy cycle via SETTLE.
            if (req.hx != 4'd0)      state <= SEQ_HSTEP;
            else if (req.hv != 4'd0) state <= SEQ_VSTEP;
            else                     state <= SEQ_SETTLE;
          end
        end
        SEQ_HSTEP: begin
          hx_cnt <= h_abort ? 4'd0 : hx_cnt - 4'd1;
          state  <= SEQ_SETTLE;
        end
        SEQ_VSTEP: begin
          hv_cnt <= v_abort ? 4'd0 : hv_cnt - 4'd1;
          state  <= SEQ_SETTLE;
        end
        SEQ_SETTLE: begin
          if (hx_cnt != 4'd0)      state <= SEQ_HSTEP;
          else if (hv_cnt != 4'd0) state <= SEQ_VSTEP;
          else                     state <= SEQ_IDLE;
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

  assign h_step = (state == SEQ_HSTEP);
  assign v_step = (state == SEQ_VSTEP);
  assign busy   = (state != SEQ_IDLE);

endmodule

// File: rtl/blue_motion.sv
// Blue sprite motion controller: per-frame key/contact decode, jump/fall physics
// and the position registers, stepped one pixel at a time by blue_step_seq.
module blue_motion
  import blue_motion_pkg::*;
#(
  parameter logic [9:0] X_INIT  = 10'd40,
  parameter logic [8:0] Y_INIT  = 9'd300,
  parameter int         STEP_X  = 2,
  parameter int         JUMP_V0 = 8,
  parameter int         V_MAX   = 6,
  parameter logic [9:0] X_MAX   = 10'(SCREEN_W - SPRITE_W),
  parameter logic [8:0] Y_MAX   = 9'(SCREEN_H - SPRITE_H)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] v_state,
  output logic       busy,
  output logic       overrun
);

  localparam logic [3:0] VY_JUMP = 4'(JUMP_V0);
  localparam logic [3:0] VY_MAX  = 4'(V_MAX);

  logic      start;
  logic      h_step, v_step;
  logic      h_abort, v_abort;
  logic      go_right, go_up;
  logic [3:0] vy;
  step_req_t req;

  assign start = frame_tick & ~busy;

  always_comb begin
    req = '0;
    if (key_left ^ key_right) req.hx = 4'(STEP_X);
    if (v_state == V_RISE || v_state == V_FALL) req.hv = vy;
  end

  // Bounds are tested before the move so the unsigned position never wraps.
  assign h_abort = go_right ? (is_collision[COLL_WALL_R] || x_blue == X_MAX)
                            : (is_collision[COLL_WALL_L] || x_blue == 10'd0);
  assign v_abort = go_up    ? (is_collision[COLL_CEIL]   || y_blue == 9'd0)
                            : (is_collision[COLL_FLOOR]  || y_blue == Y_MAX);

  blue_step_seq u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .req     (req),
    .h_abort (h_abort),
    .v_abort (v_abort),
    .h_step  (h_step),
    .v_step  (v_step),
    .busy    (busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_blue   <= X_INIT;
      y_blue   <= Y_INIT;
      v_state  <= V_FALL;
      vy       <= 4'd0;
      go_right <= 1'b0;
      go_up    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= frame_tick & busy;
      if (start) begin
        go_right <= key_right;
        // Direction is frozen for the burst; the apex frame still steps upward
        // even though v_state has already flipped to FALL.
        go_up    <= (v_state == V_RISE);
        case (v_state)
          V_GROUND: begin
            if (key_jump) begin
              v_state <= V_RISE;
              vy      <= VY_JUMP;
            end else if (!is_collision[COLL_FLOOR]) begin
              v_state <= V_FALL;
              vy      <= 4'd1;
            end
          end
          V_RISE: begin
            if (vy <= 4'd1) begin
              v_state <= V_FALL;
              vy      <= 4'd0;
            end else begin
              vy <= vy - 4'd1;
            end
          end
          V_FALL:  vy <= sat_inc(vy, VY_MAX);
          default: begin
            v_state <= V_FALL;
            vy      <= 4'd0;
          end
        endcase
      end
      if (h_step && !h_abort)
        x_blue <= go_right ? x_blue + 10'd1 : x_blue - 10'd1;
      if (v_step) begin
        if (v_abort) begin
          v_state <= go_up ? V_FALL : V_GROUND;
          vy      <= 4'd0;
        end else begin
          y_blue <= go_up ? y_blue - 9'd1 : y_blue + 9'd1;
        end
      end
    end
  end

endmodule
